sum_to_bcd: RTL and testbench

Consumer end of the adder_submodule result interface (sum/valid). It captures each new 14-bit binary sum and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. The 4-digit BCD word feeds the display/multiplex stage. The converted value is held stable between conversions.

---
 rtl/sum_to_bcd_pkg.sv | 19 +
 rtl/sum_to_bcd_if.sv | 25 ++
 rtl/sum_to_bcd_add3.sv | 9 +
 rtl/sum_to_bcd.sv | 124 ++++++++++++
 tb/tb_sum_to_bcd.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sum_to_bcd_pkg.sv
// Shared types and constants for the binary-sum to packed-BCD converter.
package sum_to_bcd_pkg;

    localparam int unsigned BIN_W_DEF  = 14;
    localparam int unsigned DIGITS_DEF = 4;
    localparam int unsigned BCD_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must be able to hold the value bin_w itself.
    function automatic int unsigned cnt_width(input int unsigned bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/sum_to_bcd_if.sv
// Adder result channel (sum/valid) plus the BCD result returned to the display side.
interface sum_to_bcd_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [BIN_W-1:0] sum;
    logic             valid;
    logic [BCD_W-1:0] bcd;
    logic             bcd_valid;
    logic             ovf;
    logic             busy;

    modport master (
        output sum, valid,
        input  bcd, bcd_valid, ovf, busy
    );

    modport slave (
        input  sum, valid,
        output bcd, bcd_valid, ovf, busy
    );

endinterface

// File: rtl/sum_to_bcd_add3.sv
// Double-dabble digit correction: add 3 to any nibble of 5 or more before the shift.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/sum_to_bcd.sv
// Captures a binary sum on a rising edge of valid and converts it to packed BCD
// one bit per clock; the result is held until the next conversion completes.
module sum_to_bcd
    import sum_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    sum_to_bcd_if.slave  bus
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = 4 * (DIGITS + 1);
    localparam int unsigned CNT_W  = cnt_width(BIN_W);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]        r_state,     w_state_nxt;
    logic              r_valid_q;
    logic [BIN_W-1:0]  r_bin,       w_bin_nxt;
    logic [WORK_W-1:0] r_work,      w_work_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [BCD_W-1:0]  r_bcd,       w_bcd_nxt;
    logic              r_ovf,       w_ovf_nxt;
    logic              r_bcd_valid, w_bcd_valid_nxt;
    logic              r_busy,      w_busy_nxt;

    logic [WORK_W-1:0] w_work_adj;
    logic [BIN_W-1:0]  w_sum;
    logic              w_valid;
    logic              w_start;

    assign w_sum   = bus.sum;
    assign w_valid = bus.valid;
    assign w_start = w_valid & ~r_valid_q;

    // One correction cell per working digit, including the overflow digit.
    for (genvar g = 0; g < int'(DIGITS + 1); g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib   (r_work[4*g +: 4]),
            .o_nib_c (w_work_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_valid_q   <= 1'b0;
            r_bin       <= '0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid_q   <= w_valid;
            r_bin       <= w_bin_nxt;
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bcd       <= w_bcd_nxt;
            r_ovf       <= w_ovf_nxt;
            r_bcd_valid <= w_bcd_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bin_nxt       = r_bin;
        w_work_nxt      = r_work;
        w_cnt_nxt       = r_cnt;
        w_bcd_nxt       = r_bcd;
        w_ovf_nxt       = r_ovf;
        w_bcd_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_bin_nxt   = w_sum;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_work_nxt = {w_work_adj[WORK_W-2:0], r_bin[BIN_W-1]};
                w_bin_nxt  = {r_bin[BIN_W-2:0], 1'b0};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_cnt_nxt == CNT_W'(BIN_W)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A nonzero top digit means the sum exceeds the displayable range.
                if (r_work[WORK_W-1 -: 4] != 4'd0) begin
                    w_bcd_nxt = {DIGITS{4'h9}};
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_bcd_nxt = r_work[BCD_W-1:0];
                    w_ovf_nxt = 1'b0;
                end
                w_bcd_valid_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign bus.bcd       = r_bcd;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sum_to_bcd.sv
// Directed self-checking bench for sum_to_bcd with hand-computed BCD results.
module tb_sum_to_bcd;
    import sum_to_bcd_pkg::*;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    sum_to_bcd_if #(.BIN_W(14), .DIGITS(4)) bus ();

    sum_to_bcd #(.BIN_W(14), .DIGITS(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle valid pulse; returns at the falling edge right after the capture edge.
    task automatic pulse_valid(input logic [13:0] s);
        @(negedge clk);
        bus.sum   = s;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.sum   = 14'h3fff;
    endtask

    task automatic run_conv(input string tag, input logic [13:0] s,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat;
        int busy_cnt;
        pulse_valid(s);
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.bcd_valid === 1'b1) break;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk({tag, "_lat"},  32'(lat), 32'd15);
        chk({tag, "_busy"}, 32'(busy_cnt), 32'd15);
        chk({tag, "_bcd"},  32'(bus.bcd), 32'(exp_bcd));
        chk({tag, "_ovf"},  32'(bus.ovf), 32'(exp_ovf));
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse1"}, 32'(bus.bcd_valid), 32'd0);
        chk({tag, "_hold"},   32'(bus.bcd), 32'(exp_bcd));
    endtask

    initial begin
        int pulses;
        logic [15:0] seen_bcd;

        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        bus.valid = 1'b0;
        bus.sum   = '0;

        repeat (3) @(negedge clk);
        chk("rst_bcd",  32'(bus.bcd), 32'd0);
        chk("rst_bval", 32'(bus.bcd_valid), 32'd0);
        chk("rst_ovf",  32'(bus.ovf), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_conv("s579",  14'd579,  16'h0579, 1'b0);
        run_conv("s1998", 14'd1998, 16'h1998, 1'b0);
        run_conv("s0",    14'd0,    16'h0000, 1'b0);
        run_conv("s12000",14'd12000,16'h9999, 1'b1);
        run_conv("s999",  14'd999,  16'h0999, 1'b0);
        run_conv("smax",  14'(BCD_MAX), 16'h9999, 1'b0);
        run_conv("s10000",14'd10000,16'h9999, 1'b1);
        run_conv("s16383",14'd16383,16'h9999, 1'b1);
        run_conv("s8421", 14'd8421, 16'h8421, 1'b0);

        // valid held high: only the initial rising edge may start a conversion
        @(negedge clk);
        bus.sum   = 14'd1234;
        bus.valid = 1'b1;
        pulses    = 0;
        seen_bcd  = '0;
        repeat (40) begin
            @(negedge clk);
            if (bus.bcd_valid === 1'b1) begin
                pulses++;
                seen_bcd = bus.bcd;
            end
        end
        bus.valid = 1'b0;
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_bcd",    32'(seen_bcd), 32'h1234);
        repeat (20) @(negedge clk);
        chk("hold_stable", 32'(bus.bcd), 32'h1234);

        // second rising edge while busy is dropped
        pulse_valid(14'd777);
        repeat (4) @(negedge clk);
        bus.sum   = 14'd42;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        pulses    = 0;
        seen_bcd  = '0;
        repeat (40) begin
            @(negedge clk);
            if (bus.bcd_valid === 1'b1) begin
                pulses++;
                seen_bcd = bus.bcd;
            end
        end
        chk("retrig_pulses", 32'(pulses), 32'd1);
        chk("retrig_bcd",    32'(seen_bcd), 32'h0777);
        chk("retrig_busy",   32'(bus.busy), 32'd0);

        // reset in the middle of shifting aborts without a result pulse
        pulse_valid(14'd456);
        repeat (6) @(negedge clk);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_bcd",  32'(bus.bcd), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ovf",  32'(bus.ovf), 32'd0);
        chk("abort_bval", 32'(bus.bcd_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.bcd_valid === 1'b1) pulses++;
        end
        chk("abort_nopulse", 32'(pulses), 32'd0);
        chk("abort_bcd_post", 32'(bus.bcd), 32'd0);

        run_conv("s321", 14'd321, 16'h0321, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
